t02_decode_queue: RTL and testbench

T02_DECODE_QUEUE -- requirements
Module: t02_decode_queue

---
 rtl/t02_decode_queue.sv | 244 ++++++++++++++++++++++++
 tb/tb_t02_decode_queue.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t02_decode_queue.sv
// t02_decode_queue: a DEPTH-entry circular FIFO of raw RV32I instructions.
// The head entry is decoded combinationally into register indices, a
// sign-extended immediate, an ALU operation code and control strobes.
// Illegal head entries are counted as they are popped (saturating).
// Optional build macro: T02_DECODE_MEXT_EN -- when defined, R-type with
// funct7=0000001 is decoded as legal RV32M (alu_op = 10 + funct3).
//
// Handshake: a push happens on a rising edge where in_valid && in_ready;
// a pop happens on a rising edge where out_valid && out_ready. in_ready
// depends only on occupancy (never on out_ready), out_valid only on
// occupancy, so neither side combinationally depends on the other.
module t02_decode_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [4:0]               out_rd,
    output logic [31:0]              out_imm,
    output logic [4:0]               out_alu_op,
    output logic [2:0]               out_funct3,
    output logic [6:0]               out_opcode,
    output logic                     out_reg_write,
    output logic                     out_mem_write,
    output logic                     out_mem_read,
    output logic                     out_alu_src,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         illegal_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    FULL_C  = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_OR   = 5'd2;
    localparam logic [4:0] ALU_XOR  = 5'd3;
    localparam logic [4:0] ALU_AND  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRA  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SRL  = 5'd9;

    logic [31:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_illegal_cnt;

    logic        w_push;
    logic        w_pop;
    logic [31:0] w_instr;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm;
    logic [4:0]  w_alu;
    logic        w_rw;
    logic        w_mw;
    logic        w_mr;
    logic        w_as;
    logic        w_ill;

    // ALU op shared by register and immediate arithmetic; bit 30 picks SUB/SRA.
    function automatic logic [4:0] arith_op(input logic [2:0] f3, input logic b30,
                                            input logic is_r);
        logic [4:0] op;
        case (f3)
            3'b000:  op = (is_r && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    assign in_ready    = (r_count < FULL_C);
    assign out_valid   = (r_count != '0);
    assign w_push      = in_valid && in_ready;
    assign w_pop       = out_valid && out_ready;
    assign count       = r_count;
    assign illegal_cnt = r_illegal_cnt;

    // Instruction storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wptr] <= in_instr;
        end
    end

    // Pointers and occupancy; flush wins over any push or pop.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Saturating count of illegal instructions actually popped.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_illegal_cnt <= '0;
        end else if (w_pop && w_ill && !flush && (r_illegal_cnt != CNT_MAX)) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    assign w_instr = r_mem[r_rptr];
    assign w_f3    = w_instr[14:12];
    assign w_f7    = w_instr[31:25];

    // Head-entry decode: immediate, ALU op, strobes and legality.
    always_comb begin
        w_imm = 32'h0;
        w_alu = ALU_ADD;
        w_rw  = 1'b0;
        w_mw  = 1'b0;
        w_mr  = 1'b0;
        w_as  = 1'b0;
        w_ill = 1'b0;
        case (w_instr[6:0])
            OP_LUI, OP_AUIPC: begin
                w_imm = {w_instr[31:12], 12'h000};
                w_rw  = 1'b1;
            end
            OP_JAL: begin
                w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                         w_instr[30:21], 1'b0};
                w_rw  = 1'b1;
            end
            OP_JALR: begin
                w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
                w_rw  = 1'b1;
                w_as  = 1'b1;
                w_ill = (w_f3 != 3'b000);
            end
            OP_BRANCH: begin
                w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                         w_instr[11:8], 1'b0};
                w_alu = ALU_SUB;
                w_ill = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            OP_LOAD: begin
                w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
                w_rw  = 1'b1;
                w_mr  = 1'b1;
                w_as  = 1'b1;
                w_ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            OP_STORE: begin
                w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                w_mw  = 1'b1;
                w_as  = 1'b1;
                w_ill = (w_f3 >= 3'b011);
            end
            OP_ITYPE: begin
                w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
                w_alu = arith_op(w_f3, w_instr[30], 1'b0);
                w_rw  = 1'b1;
                w_as  = 1'b1;
                // Only the shift-immediates carry a funct7 field.
                if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) begin
                    w_ill = !((w_f7 == 7'b0000000) ||
                              ((w_f7 == 7'b0100000) && (w_f3 == 3'b101)));
                end
            end
            OP_RTYPE: begin
                w_rw = 1'b1;
`ifdef T02_DECODE_MEXT_EN
                if (w_f7 == 7'b0000001) begin
                    w_alu = 5'd10 + {2'b00, w_f3};
                end else begin
                    w_alu = arith_op(w_f3, w_instr[30], 1'b1);
                    w_ill = !((w_f7 == 7'b0000000) ||
                              ((w_f7 == 7'b0100000) &&
                               ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
                end
`else
                w_alu = arith_op(w_f3, w_instr[30], 1'b1);
                w_ill = !((w_f7 == 7'b0000000) ||
                          ((w_f7 == 7'b0100000) &&
                           ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
`endif
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
        if (w_ill) begin
            w_rw = 1'b0;
            w_mw = 1'b0;
            w_mr = 1'b0;
            w_as = 1'b0;
        end
    end

    assign out_rs1       = w_instr[19:15];
    assign out_rs2       = w_instr[24:20];
    assign out_rd        = w_instr[11:7];
    assign out_funct3    = w_f3;
    assign out_opcode    = w_instr[6:0];
    assign out_imm       = w_imm;
    assign out_alu_op    = w_alu;
    assign out_reg_write = w_rw;
    assign out_mem_write = w_mw;
    assign out_mem_read  = w_mr;
    assign out_alu_src   = w_as;
    assign out_illegal   = w_ill;

endmodule

// File: tb/tb_t02_decode_queue.sv
// Bench for t02_decode_queue: directed scenarios followed by random traffic.
// Two instances share the stimulus; the second uses CNT_W=2 to exercise
// illegal-counter saturation.
module tb_t02_decode_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic [2:0]  f3;
        logic [6:0]  op;
        logic        rw;
        logic        mw;
        logic        mr;
        logic        as;
        logic        ill;
    } dec_t;

    // ALU code for the register/immediate arithmetic group, by funct3.
    localparam int ALU_BY_F3 [8] = '{0, 5, 8, 7, 3, 9, 2, 4};

    logic        clk = 1'b0;
    logic        nRst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [4:0]  out_rs1, out_rs2, out_rd, out_alu_op;
    logic [31:0] out_imm;
    logic [2:0]  out_funct3;
    logic [6:0]  out_opcode;
    logic        out_reg_write, out_mem_write, out_mem_read, out_alu_src, out_illegal;
    logic [2:0]  count;
    logic [15:0] illegal_cnt;

    logic        s_in_ready, s_out_valid;
    logic [4:0]  s_rs1, s_rs2, s_rd, s_alu_op;
    logic [31:0] s_imm;
    logic [2:0]  s_funct3;
    logic [6:0]  s_opcode;
    logic        s_rw, s_mw, s_mr, s_as, s_ill;
    logic [2:0]  s_count;
    logic [1:0]  s_illegal_cnt;

    dec_t exp_q[$];
    int   m_cnt  = 0;
    int   m_cnt2 = 0;
    int   errors = 0;
    int   checks = 0;

    t02_decode_queue #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .nRst(nRst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_funct3(out_funct3), .out_opcode(out_opcode),
        .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
        .out_mem_read(out_mem_read), .out_alu_src(out_alu_src), .out_illegal(out_illegal),
        .count(count), .illegal_cnt(illegal_cnt)
    );

    t02_decode_queue #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .nRst(nRst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_rs1(s_rs1), .out_rs2(s_rs2), .out_rd(s_rd), .out_imm(s_imm),
        .out_alu_op(s_alu_op), .out_funct3(s_funct3), .out_opcode(s_opcode),
        .out_reg_write(s_rw), .out_mem_write(s_mw), .out_mem_read(s_mr),
        .out_alu_src(s_as), .out_illegal(s_ill),
        .count(s_count), .illegal_cnt(s_illegal_cnt)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int w);
        return v[w-1] ? (v | (32'hFFFF_FFFF << w)) : v;
    endfunction

    // Reference decode straight from the RV32I instruction tables.
    function automatic dec_t model_decode(input logic [31:0] i);
        dec_t       d;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [7:0] f3_ok;
        logic       f7_ok;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        d = '0;
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.rd  = i[11:7];
        d.f3  = f3;
        d.op  = op;
        f3_ok = 8'hFF;
        f7_ok = 1'b1;
        case (op)
            7'b0110111, 7'b0010111: begin
                d.imm = {i[31:12], 12'h000};
                d.rw  = 1'b1;
            end
            7'b1101111: begin
                d.imm = sx({11'h0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
                d.rw  = 1'b1;
            end
            7'b1100111: begin
                d.imm = sx({20'h0, i[31:20]}, 12);
                d.rw = 1'b1; d.as = 1'b1;
                f3_ok = 8'h01;
            end
            7'b1100011: begin
                d.imm = sx({19'h0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
                d.alu = 5'd1;
                f3_ok = 8'hF3;
            end
            7'b0000011: begin
                d.imm = sx({20'h0, i[31:20]}, 12);
                d.rw = 1'b1; d.mr = 1'b1; d.as = 1'b1;
                f3_ok = 8'h37;
            end
            7'b0100011: begin
                d.imm = sx({20'h0, i[31:25], i[11:7]}, 12);
                d.mw = 1'b1; d.as = 1'b1;
                f3_ok = 8'h07;
            end
            7'b0010011: begin
                d.imm = sx({20'h0, i[31:20]}, 12);
                d.rw = 1'b1; d.as = 1'b1;
                d.alu = 5'(ALU_BY_F3[f3]);
                if (f3 == 3'd5 && i[30]) d.alu = 5'd6;
                if (f3 == 3'd1 || f3 == 3'd5)
                    f7_ok = (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
            end
            7'b0110011: begin
                d.rw = 1'b1;
                d.alu = 5'(ALU_BY_F3[f3]);
                if (f3 == 3'd0 && i[30]) d.alu = 5'd1;
                if (f3 == 3'd5 && i[30]) d.alu = 5'd6;
                f7_ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
`ifdef T02_DECODE_MEXT_EN
                if (f7 == 7'h01) begin
                    d.alu = 5'(10 + int'(f3));
                    f7_ok = 1'b1;
                end
`endif
            end
            default: begin
                f3_ok = 8'h00;
            end
        endcase
        d.ill = !f3_ok[f3] || !f7_ok;
        if (d.ill) begin
            d.rw = 1'b0; d.mw = 1'b0; d.mr = 1'b0; d.as = 1'b0;
        end
        return d;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [6:0]  ops [9];
        int          s;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
        r = $urandom;
        s = $urandom_range(0, 11);
        if (s < 9) r[6:0] = ops[s];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        return r;
    endfunction

    // Drive one cycle of inputs shortly after the rising edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy,
                         input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_instr  = ins;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: compares every presented head against the expected
    // queue, then applies this cycle's push/pop/flush to the reference.
    always @(negedge clk) begin
        int   sz;
        dec_t e;
        if (!nRst) begin
            exp_q.delete();
            m_cnt  = 0;
            m_cnt2 = 0;
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
        end else begin
            sz = exp_q.size();
            chk("in_ready", 32'(in_ready), 32'(sz < DEPTH));
            chk("out_valid", 32'(out_valid), 32'(sz != 0));
            chk("count", 32'(count), 32'(sz));
            chk("sat_count", 32'(s_count), 32'(sz));
            chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
            chk("sat_illegal_cnt", 32'(s_illegal_cnt), 32'(m_cnt2));
`ifndef T02_DECODE_MEXT_EN
            chk("alu_op_le9", 32'(out_alu_op <= 5'd9), 32'd1);
`endif
            if (sz != 0) begin
                e = exp_q[0];
                chk("rs1", 32'(out_rs1), 32'(e.rs1));
                chk("rs2", 32'(out_rs2), 32'(e.rs2));
                chk("rd", 32'(out_rd), 32'(e.rd));
                chk("funct3", 32'(out_funct3), 32'(e.f3));
                chk("opcode", 32'(out_opcode), 32'(e.op));
                chk("illegal", 32'(out_illegal), 32'(e.ill));
                chk("strobes", {28'h0, out_reg_write, out_mem_write, out_mem_read, out_alu_src},
                    {28'h0, e.rw, e.mw, e.mr, e.as});
                if (!e.ill) begin
                    chk("imm", out_imm, e.imm);
                    chk("alu_op", 32'(out_alu_op), 32'(e.alu));
                end
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_ready && sz != 0) begin
                    if (exp_q[0].ill) begin
                        m_cnt++;
                        if (m_cnt2 < 3) m_cnt2++;
                    end
                    void'(exp_q.pop_front());
                end
                if (in_valid && sz < DEPTH) exp_q.push_back(model_decode(in_instr));
            end
        end
    end

    initial begin
        nRst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 nRst = 1'b1;

        // addi x1,x0,5 into an empty queue: visible one cycle later.
        cycle(1'b1, 32'h0050_0093, 1'b0, 1'b0);
        @(negedge clk);
        chk("addi_no_bypass", 32'(out_valid), 32'd0);
        idle();
        @(negedge clk);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_rd", 32'(out_rd), 32'd1);
        chk("addi_rs1", 32'(out_rs1), 32'd0);
        chk("addi_imm", out_imm, 32'd5);
        chk("addi_alu", 32'(out_alu_op), 32'd0);
        chk("addi_rw", 32'(out_reg_write), 32'd1);
        chk("addi_as", 32'(out_alu_src), 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // beq with negative offset.
        cycle(1'b1, 32'hFE20_8EE3, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("beq_imm", out_imm, 32'hFFFF_FFFC);
        chk("beq_alu", 32'(out_alu_op), 32'd1);
        chk("beq_strobes", {28'h0, out_reg_write, out_mem_write, out_mem_read, out_alu_src}, 32'd0);
        chk("beq_funct3", 32'(out_funct3), 32'd0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill past capacity with out_ready low; the extra push is dropped.
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 32'h0000_0093 | (32'(i) << 20), 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'(DEPTH));
        // Push+pop while full: the push is refused, the pop proceeds.
        cycle(1'b1, 32'h0070_0093, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        chk("full_pushpop_count", 32'(count), 32'(DEPTH - 1));
        // Push+pop while not full: occupancy holds.
        cycle(1'b1, 32'h0080_0093, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        chk("pushpop_count", 32'(count), 32'(DEPTH - 1));
        repeat (DEPTH) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Illegal pops: three, then a fourth that saturates the 2-bit counter.
        repeat (4) cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        chk("ill3_cnt", 32'(illegal_cnt), 32'd3);
        chk("ill3_sat_cnt", 32'(s_illegal_cnt), 32'd3);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        chk("ill4_cnt", 32'(illegal_cnt), 32'd4);
        chk("ill4_sat_cnt", 32'(s_illegal_cnt), 32'd3);

        // Flush with a coincident push drops everything.
        repeat (3) cycle(1'b1, 32'h0010_0113, 1'b0, 1'b0);
        cycle(1'b1, 32'h0050_0093, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        // Flush coinciding with an illegal pop does not count it.
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        chk("flush_ill_cnt", 32'(illegal_cnt), 32'd4);

        // Asynchronous reset mid-stream.
        repeat (2) cycle(1'b1, 32'h0020_0193, 1'b0, 1'b0);
        idle();
        @(posedge clk);
        #3 nRst = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_ill_cnt", 32'(illegal_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 nRst = 1'b1;

        // mul x0,x1,x2.
        cycle(1'b1, 32'h0220_8033, 1'b0, 1'b0);
        idle();
        @(negedge clk);
`ifdef T02_DECODE_MEXT_EN
        chk("mul_illegal", 32'(out_illegal), 32'd0);
        chk("mul_alu", 32'(out_alu_op), 32'd10);
`else
        chk("mul_illegal", 32'(out_illegal), 32'd1);
`endif
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic with occasional flushes and one mid-run reset.
        for (int n = 0; n < 800; n++) begin
            if (n == 400) begin
                @(posedge clk);
                #2 nRst = 1'b0;
                @(posedge clk);
                #1 nRst = 1'b1;
            end
            cycle(1'($urandom_range(0, 3) != 0), gen_instr(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
        end
        repeat (DEPTH + 1) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
